// File: rtl/jtag_mem_pkg.sv
// Shared definitions for the JTAG memory command TDR and jtag_memory_interface.
// Field offsets describe the DR layout, which is LSB first.
package jtag_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } cmd_state_t;

    localparam int CMD_WRITE_BIT   = 0;
    localparam int CMD_AUTOINC_BIT = 1;
    localparam int DR_ADDR_LSB     = 2;
    localparam int WAIT_CNT_WIDTH  = 16;

    localparam logic [31:0] ERROR_PATTERN = 32'hDEADBEEF;

    function automatic int dr_data_lsb(input int addr_width);
        return DR_ADDR_LSB + addr_width;
    endfunction

endpackage

// File: rtl/jtag_dr_shifter.sv
// Capture/shift data register; tdo is the current LSB.
// Capture takes priority over shift.
module jtag_dr_shifter
    import jtag_mem_pkg::*;
#(
    parameter int WIDTH = 66
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             tdi_i,
    input  logic [WIDTH-1:0] capture_data_i,
    output logic [WIDTH-1:0] sr_o,
    output logic             tdo_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (capture_i) begin
            sr_d = capture_data_i;
        end else if (shift_i) begin
            sr_d = {tdi_i, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o  = sr_q;
    assign tdo_o = sr_q[0];

endmodule

// File: rtl/jtag_mem_cmd_tdr.sv
// JTAG TDR issuing single-word memory requests with bounded-wait handshake.
// Define JTAG_MEM_AUTOINC_EN to build the post-increment address pointer.
module jtag_mem_cmd_tdr
    import jtag_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tdr_select,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  mem_enable,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready,
    input  logic                  mem_error,
    output logic                  busy
);

    localparam int DR_WIDTH = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int DATA_LSB = dr_data_lsb(ADDR_WIDTH);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(TIMEOUT_CYCLES);

    cmd_state_t                state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                      write_q, write_d;
    logic                      error_q, error_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d, cmd_addr;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DR_WIDTH-1:0]       sr, cap_data;
    logic                      capture_en, shift_en, update_en;
    logic                      wait_expired, done_ok;

    assign capture_en = tdr_select & capture_dr;
    assign shift_en   = tdr_select & shift_dr & ~capture_dr;
    assign update_en  = tdr_select & update_dr & ~capture_dr & ~shift_dr;
    assign cap_data   = {data_q, addr_q, busy, error_q};

    jtag_dr_shifter #(
        .WIDTH(DR_WIDTH)
    ) u_shifter (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .capture_i     (capture_en),
        .shift_i       (shift_en),
        .tdi_i         (tdi),
        .capture_data_i(cap_data),
        .sr_o          (sr),
        .tdo_o         (tdo)
    );

    assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + WAIT_CNT_WIDTH'(1);
    assign wait_expired = (cnt_inc >= WAIT_LIMIT);
    assign done_ok      = (state_q == REQ) & mem_ready & ~mem_error;

`ifdef JTAG_MEM_AUTOINC_EN
    // Pointer tracks the last address that completed cleanly.
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    assign ptr_d    = done_ok ? addr_q : ptr_q;
    assign cmd_addr = sr[CMD_AUTOINC_BIT] ? ptr_q + ADDR_WIDTH'(4)
                                          : sr[DR_ADDR_LSB +: ADDR_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_autoinc;

    assign unused_autoinc = sr[CMD_AUTOINC_BIT] | done_ok;
    assign cmd_addr       = sr[DR_ADDR_LSB +: ADDR_WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (update_en) begin
                    write_d = sr[CMD_WRITE_BIT];
                    addr_d  = cmd_addr;
                    data_d  = sr[DATA_LSB +: DATA_WIDTH];
                    error_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    // Writes keep their data so the capture echoes it.
                    if (!write_q) begin
                        data_d = mem_read_data;
                    end
                    error_d = error_q | mem_error;
                    state_d = RELEASE;
                end else if (wait_expired) begin
                    error_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!mem_ready) begin
                    state_d = IDLE;
                end else if (wait_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (update_en && (state_q != IDLE)) begin
            error_d = 1'b1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    assign mem_enable     = (state_q == REQ);
    assign busy           = (state_q != IDLE);
    assign mem_write      = write_q;
    assign mem_address    = addr_q;
    assign mem_write_data = data_q;

endmodule

// File: tb/tb_jtag_mem_cmd_tdr.sv
// Scoreboard bench for jtag_mem_cmd_tdr: request and capture monitors check
// against expectations queued by the stimulus.
module tb_jtag_mem_cmd_tdr;
    import jtag_mem_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DRW = AW + DW + 2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tdr_select = 1'b0;
    logic          capture_dr = 1'b0;
    logic          shift_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          tdi = 1'b0;
    logic          tdo, mem_enable, mem_write, busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_ready = 1'b0;
    logic          mem_error = 1'b0;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } req_t;

    req_t           req_q[$];
    logic [DRW-1:0] cap_q[$];
    logic [31:0]    mem[logic [31:0]];
    int             n_checks = 0;
    int             n_pass = 0;
    int             cyc = 0;
    int             upd_cyc = 0;
    logic           stall = 1'b0;

    req_t           mon_e;
    logic           en_prev = 1'b0;
    logic           have_req = 1'b0;
    int             rise_cyc = 0;
    logic           cap_armed = 1'b0;
    int             cap_n = 0;
    logic [DRW-1:0] cap_word = '0;

    jtag_mem_cmd_tdr #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tdr_select    (tdr_select),
        .capture_dr    (capture_dr),
        .shift_dr      (shift_dr),
        .update_dr     (update_dr),
        .tdi           (tdi),
        .tdo           (tdo),
        .mem_enable    (mem_enable),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_ready     (mem_ready),
        .mem_error     (mem_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DRW-1:0] act, input logic [DRW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Downstream memory: one-cycle response, misaligned accesses report an error.
    initial begin : mem_model
        forever begin
            @(posedge clk);
            #1;
            if (mem_enable && !mem_ready && !stall) begin
                if (mem_address[1:0] != 2'b00) begin
                    mem_error     = 1'b1;
                    mem_read_data = ERROR_PATTERN;
                end else begin
                    mem_error = 1'b0;
                    if (mem_write) mem[mem_address] = mem_write_data;
                    mem_read_data = mem.exists(mem_address) ? mem[mem_address]
                                  : (32'hC0DE0000 | {16'h0, mem_address[15:0]});
                end
                mem_ready = 1'b1;
            end else if (!mem_enable && mem_ready) begin
                mem_ready = 1'b0;
                mem_error = 1'b0;
            end
        end
    end

    initial begin : req_mon
        forever begin
            @(negedge clk);
            if (mem_enable && !en_prev) begin
                rise_cyc = cyc;
                if (req_q.size() == 0) begin
                    have_req = 1'b0;
                    n_checks++;
                    $display("FAIL req_unexpected: got request to %h, expected none", mem_address);
                end else begin
                    mon_e    = req_q.pop_front();
                    have_req = 1'b1;
                    chk("req_write", DRW'(mem_write), DRW'(mon_e.w));
                    chk("req_addr", DRW'(mem_address), DRW'(mon_e.addr));
                    if (mon_e.w) chk("req_wdata", DRW'(mem_write_data), DRW'(mon_e.wdata));
                    chk("req_latency", DRW'(cyc - upd_cyc), DRW'(1));
                end
            end else if (!mem_enable && en_prev && have_req) begin
                chk("req_len", DRW'(cyc - rise_cyc), DRW'(mon_e.len));
                have_req = 1'b0;
            end
            en_prev = mem_enable;
        end
    end

    initial begin : cap_mon
        forever begin
            @(negedge clk);
            if (tdr_select && capture_dr) begin
                cap_armed = 1'b1;
                cap_n     = 0;
            end else if (cap_armed && tdr_select && shift_dr) begin
                cap_word[cap_n] = tdo;
                cap_n++;
                if (cap_n == DRW) begin
                    cap_armed = 1'b0;
                    if (cap_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL capture_unexpected: got %h, expected none", cap_word);
                    end else begin
                        chk("capture", cap_word, cap_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [DRW-1:0] v);
        tdr_select = 1'b1;
        for (int i = 0; i < DRW; i++) begin
            shift_dr = 1'b1;
            tdi      = v[i];
            step();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
    endtask

    task automatic issue(input logic w, input logic ai, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_a, input int len);
        req_t r;
        r.w     = w;
        r.addr  = exp_a;
        r.wdata = d;
        r.len   = len;
        req_q.push_back(r);
        shift_bits({d, a, ai, w});
        update_dr = 1'b1;
        upd_cyc   = cyc;
        step();
        update_dr = 1'b0;
    endtask

    task automatic capture(input logic [31:0] d, input logic [31:0] a, input logic b, input logic e);
        cap_q.push_back({d, a, b, e});
        tdr_select = 1'b1;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        shift_bits('0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("wait_idle_busy", DRW'(busy), '0);
    endtask

    initial begin : stim
        repeat (3) step();
        chk("rst_mem_enable", DRW'(mem_enable), '0);
        chk("rst_busy", DRW'(busy), '0);
        chk("rst_tdo", DRW'(tdo), '0);
        chk("rst_mem_write", DRW'(mem_write), '0);
        chk("rst_mem_address", DRW'(mem_address), '0);
        chk("rst_mem_write_data", DRW'(mem_write_data), '0);
        reset_n = 1'b1;
        step();
        capture(32'h0, 32'h0, 1'b0, 1'b0);

        issue(1'b1, 1'b0, 32'h10, 32'h12345678, 32'h10, 1);
        wait_idle();
        capture(32'h12345678, 32'h10, 1'b0, 1'b0);

        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h10, 1);
        wait_idle();
        capture(32'h12345678, 32'h10, 1'b0, 1'b0);

        issue(1'b0, 1'b0, 32'h1002, 32'h0, 32'h1002, 1);
        wait_idle();
        capture(ERROR_PATTERN, 32'h1002, 1'b0, 1'b1);

        // Stalled memory: capture while busy, then timeout after TMO cycles.
        stall = 1'b1;
        issue(1'b0, 1'b0, 32'h40, 32'h0, 32'h40, TMO);
        step();
        step();
        capture(32'h0, 32'h40, 1'b1, 1'b0);
        wait_idle();
        stall = 1'b0;
        capture(32'h0, 32'h40, 1'b0, 1'b1);

        // Update while busy is dropped but flags an error.
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h10, 1);
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        wait_idle();
        capture(32'h12345678, 32'h10, 1'b0, 1'b1);

        // Reset in the middle of a request.
        stall = 1'b1;
        issue(1'b0, 1'b0, 32'h80, 32'h0, 32'h80, 1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_mem_enable", DRW'(mem_enable), '0);
        chk("midrst_busy", DRW'(busy), '0);
        chk("midrst_mem_address", DRW'(mem_address), '0);
        step();
        step();
        stall   = 1'b0;
        reset_n = 1'b1;
        step();
        capture(32'h0, 32'h0, 1'b0, 1'b0);

`ifdef JTAG_MEM_AUTOINC_EN
        issue(1'b0, 1'b0, 32'h20, 32'h0, 32'h20, 1);
        wait_idle();
        issue(1'b0, 1'b1, 32'h999, 32'h0, 32'h24, 1);
        wait_idle();
        issue(1'b0, 1'b1, 32'h999, 32'h0, 32'h28, 1);
        wait_idle();
        capture(32'hC0DE0028, 32'h28, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 1);
        wait_idle();
        issue(1'b0, 1'b1, 32'h4, 32'h0, 32'h0, 1);
        wait_idle();
        capture(32'hC0DE0000, 32'h0, 1'b0, 1'b0);
`else
        issue(1'b0, 1'b1, 32'h10, 32'h0, 32'h10, 1);
        wait_idle();
        capture(32'h12345678, 32'h10, 1'b0, 1'b0);
`endif

        repeat (4) step();
        chk("req_queue_empty", DRW'(req_q.size()), '0);
        chk("cap_queue_empty", DRW'(cap_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
